multicycle_control: RTL and testbench
=====================================

# multicycle_control

Parametrised multi-cycle control sequencer for the lab CPU. It replaces single-cycle opcode decoding with an FSM that fetches over a valid/ready handshake, decodes, executes, waits on memory, and writes back. It sits between the instruction memory port and the datapath. It drives registered ALU, register-file and memory controls, plus PC_EN, HALTED, ILLEGAL and TIMEOUT status.

## Interface
- OPCODE_W, 4: opcode width; opcodes at or above 2**4 are not defined.
- REG_W, 3: register-index width.
- MEM_ADDR_W, 9: width of MEM_TO_READ_FROM.
- WR_ADDR1 / WR_ADDR2 / WR_ADDR3, 18 / 19 / 96: memory source for WRREG when WR_REG is 1 / 2 / 3.
- MEM_TIMEOUT, 15: maximum number of MEM_WAIT cycles before fault.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  reset, asynchronous, active-low.
- START  in  1  leaves IDLE.
- INSTR_VALID  in  1  OPCODE/WR_REG valid.
- INSTR_READY  out  1  sequencer accepts an instruction.
- OPCODE  in  OPCODE_W  instruction opcode.
- WR_REG  in  REG_W  register selector field.
- MEM_READY  in  1  memory access complete.
- ALU_OP  out  OPCODE_W  ALU operation.
- ALU_SRC_B  out  2  B-operand select: 0 reg, 1 imm, 2 zero.
- REG_WRITE, MEM_READ, MEM_WRITE, MEM_TO_REG, IMMEDIATE, WRFLAG  out  1 each  datapath controls.
- WRITE_REG, SRCA  out  REG_W  destination / A-source register.
- MEM_TO_READ_FROM  out  MEM_ADDR_W  fixed memory source address.
- PC_EN  out  1  one-cycle PC advance.
- HALTED, ILLEGAL, TIMEOUT  out  1 each  sticky status.

## Operation
- Opcodes and their writes:
  - 0 ADD: writes.
  - 1 HALT.
  - 2 SUB: writes.
  - 3 WRREG: MEM_READ, MEM_TO_REG, ALU_SRC_B=2, REG_DST-style write to WR_REG; WR_REG 1/2/3 maps to WR_ADDR1/2/3 with WRFLAG=1; any other WR_REG gives address 0, WRFLAG=0, WRITE_REG=0.
  - 4 SEARCH: MEM_READ, WRITE_REG=3, SRCA=1.
  - 5 BEQ: IMMEDIATE, ALU_SRC_B=2, WRITE_REG=6, SRCA=6.
  - 6 WRMEM: MEM_WRITE, IMMEDIATE, SRCA=7, no register write.
  - 7 SETMEM: IMMEDIATE, WRITE_REG=6.
  - 8 RXOR: MEM_READ, MEM_TO_REG, WRITE_REG=7, SRCA=7.
  - 9 SRL: WRITE_REG=7, SRCA=6.
  - 10 BSEARCH: IMMEDIATE, WRITE_REG=6, SRCA=6.
  - 15 NOP: no write.
  - ALU_OP equals the opcode for all of the above, except 15, which gives 0.
- Illegal opcodes are 11–14 and any value at or above 16. An illegal opcode sets ILLEGAL and enters HALT.
- Every decoded field has a defined value for every opcode; unspecified fields are 0.
- States are IDLE, FETCH, DECODE, EXEC, MEM_WAIT, WB, HALT.
  - IDLE → FETCH when START=1.
  - FETCH: INSTR_READY=1. On INSTR_VALID, capture OPCODE and WR_REG and go to DECODE.
  - DECODE: register the decoded word. HALT or illegal opcode → HALT; otherwise → EXEC.
  - EXEC → MEM_WAIT if MEM_READ or MEM_WRITE; otherwise → WB.
  - MEM_WAIT → WB on MEM_READY. If the wait counter reaches MEM_TIMEOUT without MEM_READY, set TIMEOUT and go to HALT.
  - WB: REG_WRITE per decode, PC_EN=1, → FETCH.
  - HALT is terminal until RST_N falls; START is ignored there.
- Output gating:
  - MEM_READ and MEM_WRITE are asserted only in EXEC and MEM_WAIT.
  - REG_WRITE is asserted only in WB.
  - The remaining decoded fields are held from EXEC through WB, and are zero in all other states.

## Timing
- Reset forces IDLE, all outputs 0, HALTED/ILLEGAL/TIMEOUT 0, and wait counter 0.
- Reset mid-instruction aborts the instruction with no pending REG_WRITE or MEM_WRITE.
- Handshake: a transfer occurs on a rising edge with INSTR_VALID & INSTR_READY. INSTR_READY is a registered state decode and never depends on INSTR_VALID.
- Latency from accepted instruction to PC_EN:
  - non-memory instruction: 3 cycles (DECODE, EXEC, WB);
  - memory instruction: 3 + N cycles, where N is the number of MEM_WAIT cycles. N is 1 if MEM_READY is already high on the first MEM_WAIT cycle.
- The wait counter is $clog2(MEM_TIMEOUT+1) bits wide. It clears on entry to MEM_WAIT, saturates, and never wraps.
- MEM_READY arriving in the same cycle the counter hits MEM_TIMEOUT counts as success: go to WB, TIMEOUT stays 0.
- HALTED rises on the cycle HALT is entered.
- ILLEGAL and TIMEOUT are mutually exclusive; each stays sticky.

## Structure
- Package control_pkg holds:
  - opcode localparams (OP_ADD … OP_NOP);
  - the state enum;
  - ALU_SRC_B encodings;
  - a packed struct ctrl_t for the decoded control word.
- Sub-module control_decode: purely combinational. Maps the captured OPCODE/WR_REG and parameters to ctrl_t plus an illegal flag.
- multicycle_control contains the FSM, capture registers, wait counter and output gating.

## Test plan
- Reset then START, accept opcode 0 → PC_EN exactly 3 cycles after the handshake; REG_WRITE=1 only in WB; ALU_OP=0.
- Opcode 3 with WR_REG=2, MEM_READY asserted after 2 wait cycles → MEM_TO_READ_FROM=19, WRFLAG=1, WRITE_REG=2, MEM_READ high for EXEC plus 2 cycles, PC_EN 5 cycles after the handshake.
- Opcode 3 with WR_REG=5 → MEM_TO_READ_FROM=0, WRFLAG=0, WRITE_REG=0.
- Opcode 6 with MEM_READY held low → TIMEOUT=1 and HALTED=1 after 15 MEM_WAIT cycles, MEM_WRITE drops, and START is subsequently ignored.
- Opcode 12 → ILLEGAL=1, HALTED=1, no REG_WRITE or PC_EN ever.
- RST_N low during MEM_WAIT of opcode 8 → all outputs 0 immediately; after release and START, the sequencer returns to FETCH with INSTR_READY=1.

Source files
------------

// File: rtl/control_pkg.sv
// Shared definitions for the multi-cycle control sequencer.
//   - opcode values OP_ADD .. OP_NOP
//   - sequencer state enum
//   - ALU B-operand select encodings
//   - ctrl_t: the fixed-width part of the decoded control word. The
//     parameter-sized fields (ALU op, register indices, memory address)
//     travel alongside it because their widths belong to the instance.
package control_pkg;

  localparam int OP_ADD     = 0;
  localparam int OP_HALT    = 1;
  localparam int OP_SUB     = 2;
  localparam int OP_WRREG   = 3;
  localparam int OP_SEARCH  = 4;
  localparam int OP_BEQ     = 5;
  localparam int OP_WRMEM   = 6;
  localparam int OP_SETMEM  = 7;
  localparam int OP_RXOR    = 8;
  localparam int OP_SRL     = 9;
  localparam int OP_BSEARCH = 10;
  localparam int OP_NOP     = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM_WAIT,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [1:0] {
    SRC_B_REG  = 2'd0,
    SRC_B_IMM  = 2'd1,
    SRC_B_ZERO = 2'd2
  } alu_src_b_t;

  typedef struct packed {
    alu_src_b_t alu_src_b;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       immediate;
    logic       wrflag;
  } ctrl_t;

  // An instruction needs the MEM_WAIT phase when it touches memory.
  function automatic logic needs_mem(ctrl_t c);
    return c.mem_read | c.mem_write;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Purely combinational opcode decoder for the multi-cycle sequencer.
// Ports:
//   opcode, wr_reg        in   captured instruction fields
//   ctrl                  out  flag part of the decoded control word
//   alu_op                out  ALU operation (opcode, NOP gives 0)
//   write_reg, srca       out  destination / A-source register
//   mem_addr              out  fixed memory source address (WRREG only)
//   halt, illegal         out  opcode is HALT / opcode is not defined
module control_decode
  import control_pkg::*;
#(
  parameter int OPCODE_W   = 4,
  parameter int REG_W      = 3,
  parameter int MEM_ADDR_W = 9,
  parameter int WR_ADDR1   = 18,
  parameter int WR_ADDR2   = 19,
  parameter int WR_ADDR3   = 96
) (
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [REG_W-1:0]      wr_reg,
  output ctrl_t                 ctrl,
  output logic [OPCODE_W-1:0]   alu_op,
  output logic [REG_W-1:0]      write_reg,
  output logic [REG_W-1:0]      srca,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  halt,
  output logic                  illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    ctrl      = '0;
    alu_op    = opcode;
    write_reg = '0;
    srca      = '0;
    mem_addr  = '0;
    halt      = 1'b0;
    illegal   = 1'b0;

    // Any opcode that names a destination register also writes it.
    case (int'(opcode))
      OP_ADD, OP_SUB: ctrl.reg_write = 1'b1;
      OP_HALT:        halt = 1'b1;
      OP_WRREG: begin
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src_b  = SRC_B_ZERO;
        ctrl.reg_write  = 1'b1;
        // Only selectors 1..3 name a source; anything else leaves the
        // address, flag and destination at zero.
        case (int'(wr_reg))
          1: mem_addr = MEM_ADDR_W'(WR_ADDR1);
          2: mem_addr = MEM_ADDR_W'(WR_ADDR2);
          3: mem_addr = MEM_ADDR_W'(WR_ADDR3);
          default: mem_addr = '0;
        endcase
        if (int'(wr_reg) >= 1 && int'(wr_reg) <= 3) begin
          ctrl.wrflag = 1'b1;
          write_reg   = wr_reg;
        end
      end
      OP_SEARCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.reg_write = 1'b1;
        write_reg      = REG_W'(3);
        srca           = REG_W'(1);
      end
      OP_BEQ: begin
        ctrl.immediate = 1'b1;
        ctrl.alu_src_b = SRC_B_ZERO;
        ctrl.reg_write = 1'b1;
        write_reg      = REG_W'(6);
        srca           = REG_W'(6);
      end
      OP_WRMEM: begin
        ctrl.mem_write = 1'b1;
        ctrl.immediate = 1'b1;
        srca           = REG_W'(7);
      end
      OP_SETMEM: begin
        ctrl.immediate = 1'b1;
        ctrl.reg_write = 1'b1;
        write_reg      = REG_W'(6);
      end
      OP_RXOR: begin
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        write_reg       = REG_W'(7);
        srca            = REG_W'(7);
      end
      OP_SRL: begin
        ctrl.reg_write = 1'b1;
        write_reg      = REG_W'(7);
        srca           = REG_W'(6);
      end
      OP_BSEARCH: begin
        ctrl.immediate = 1'b1;
        ctrl.reg_write = 1'b1;
        write_reg      = REG_W'(6);
        srca           = REG_W'(6);
      end
      OP_NOP: alu_op = '0;
      default: begin
        alu_op  = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer: fetches an instruction over a valid/ready
// handshake, decodes it, executes, waits on memory and writes back.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start                    leaves IDLE
//   instr_valid/instr_ready  instruction handshake (ready = in FETCH)
//   opcode, wr_reg           instruction fields, captured on handshake
//   mem_ready                memory access complete
//   alu_op, alu_src_b, reg_write, mem_read, mem_write, mem_to_reg,
//   immediate, wrflag, write_reg, srca, mem_to_read_from
//                            registered datapath controls
//   pc_en                    one-cycle PC advance in WB
//   halted, illegal, timeout sticky status
module multicycle_control
  import control_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int REG_W       = 3,
  parameter int MEM_ADDR_W  = 9,
  parameter int WR_ADDR1    = 18,
  parameter int WR_ADDR2    = 19,
  parameter int WR_ADDR3    = 96,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [REG_W-1:0]      wr_reg,
  input  logic                  mem_ready,
  output logic [OPCODE_W-1:0]   alu_op,
  output logic [1:0]            alu_src_b,
  output logic                  reg_write,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_to_reg,
  output logic                  immediate,
  output logic                  wrflag,
  output logic [REG_W-1:0]      write_reg,
  output logic [REG_W-1:0]      srca,
  output logic [MEM_ADDR_W-1:0] mem_to_read_from,
  output logic                  pc_en,
  output logic                  halted,
  output logic                  illegal,
  output logic                  timeout
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  state_t                state, state_nxt;
  logic [OPCODE_W-1:0]   opcode_q;
  logic [REG_W-1:0]      wr_reg_q;

  // Decoder outputs for the captured instruction.
  ctrl_t                 dec_ctrl;
  logic [OPCODE_W-1:0]   dec_alu_op;
  logic [REG_W-1:0]      dec_write_reg, dec_srca;
  logic [MEM_ADDR_W-1:0] dec_addr;
  logic                  dec_halt, dec_illegal;

  // Decoded word registered in DECODE, held for the rest of the instruction.
  ctrl_t                 ctrl_q;
  logic [OPCODE_W-1:0]   alu_op_q;
  logic [REG_W-1:0]      write_reg_q, srca_q;
  logic [MEM_ADDR_W-1:0] addr_q;

  // Number of MEM_WAIT cycles already spent without mem_ready.
  logic [CNT_W-1:0]      wait_cnt, wait_cnt_nxt, wait_cnt_inc;
  logic                  set_timeout, set_illegal;

  // Word feeding the output registers: on the DECODE->EXEC edge the
  // registered copy is not loaded yet, so take the decoder directly.
  ctrl_t                 src_ctrl;
  logic [OPCODE_W-1:0]   src_alu_op;
  logic [REG_W-1:0]      src_write_reg, src_srca;
  logic [MEM_ADDR_W-1:0] src_addr;
  logic                  held, mem_phase;

  control_decode #(
    .OPCODE_W  (OPCODE_W),
    .REG_W     (REG_W),
    .MEM_ADDR_W(MEM_ADDR_W),
    .WR_ADDR1  (WR_ADDR1),
    .WR_ADDR2  (WR_ADDR2),
    .WR_ADDR3  (WR_ADDR3)
  ) u_decode (
    .opcode   (opcode_q),
    .wr_reg   (wr_reg_q),
    .ctrl     (dec_ctrl),
    .alu_op   (dec_alu_op),
    .write_reg(dec_write_reg),
    .srca     (dec_srca),
    .mem_addr (dec_addr),
    .halt     (dec_halt),
    .illegal  (dec_illegal)
  );

  // Saturating increment: the counter can never wrap back to zero.
  assign wait_cnt_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + CNT_W'(1);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    set_timeout  = 1'b0;
    set_illegal  = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_FETCH;
      ST_FETCH: if (instr_valid) state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (dec_illegal) begin
          state_nxt   = ST_HALT;
          set_illegal = 1'b1;
        end else if (dec_halt) begin
          state_nxt = ST_HALT;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (needs_mem(ctrl_q)) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = '0;
        end else begin
          state_nxt = ST_WB;
        end
      end
      ST_MEM_WAIT: begin
        // mem_ready on the last allowed cycle still counts as success.
        if (mem_ready) begin
          state_nxt = ST_WB;
        end else if (wait_cnt_inc >= TIMEOUT_CNT) begin
          state_nxt   = ST_HALT;
          set_timeout = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt_inc;
        end
      end
      ST_WB:   state_nxt = ST_FETCH;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    if (state == ST_DECODE) begin
      src_ctrl      = dec_ctrl;
      src_alu_op    = dec_alu_op;
      src_write_reg = dec_write_reg;
      src_srca      = dec_srca;
      src_addr      = dec_addr;
    end else begin
      src_ctrl      = ctrl_q;
      src_alu_op    = alu_op_q;
      src_write_reg = write_reg_q;
      src_srca      = srca_q;
      src_addr      = addr_q;
    end
    held      = state_nxt inside {ST_EXEC, ST_MEM_WAIT, ST_WB};
    mem_phase = state_nxt inside {ST_EXEC, ST_MEM_WAIT};
  end

  // Outputs are registered from the state being entered, so each one is
  // a clean decode of the current state and never depends on inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      opcode_q         <= '0;
      wr_reg_q         <= '0;
      ctrl_q           <= '0;
      alu_op_q         <= '0;
      write_reg_q      <= '0;
      srca_q           <= '0;
      addr_q           <= '0;
      wait_cnt         <= '0;
      instr_ready      <= 1'b0;
      alu_op           <= '0;
      alu_src_b        <= '0;
      reg_write        <= 1'b0;
      mem_read         <= 1'b0;
      mem_write        <= 1'b0;
      mem_to_reg       <= 1'b0;
      immediate        <= 1'b0;
      wrflag           <= 1'b0;
      write_reg        <= '0;
      srca             <= '0;
      mem_to_read_from <= '0;
      pc_en            <= 1'b0;
      halted           <= 1'b0;
      illegal          <= 1'b0;
      timeout          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every register
      // samples the pre-edge values regardless of statement order.
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;

      if (state == ST_FETCH && instr_valid) begin
        opcode_q <= opcode;
        wr_reg_q <= wr_reg;
      end

      if (state == ST_DECODE) begin
        ctrl_q      <= dec_ctrl;
        alu_op_q    <= dec_alu_op;
        write_reg_q <= dec_write_reg;
        srca_q      <= dec_srca;
        addr_q      <= dec_addr;
      end

      instr_ready      <= (state_nxt == ST_FETCH);
      pc_en            <= (state_nxt == ST_WB);
      halted           <= (state_nxt == ST_HALT);
      illegal          <= illegal | set_illegal;
      timeout          <= timeout | set_timeout;

      reg_write        <= (state_nxt == ST_WB) & src_ctrl.reg_write;
      mem_read         <= mem_phase & src_ctrl.mem_read;
      mem_write        <= mem_phase & src_ctrl.mem_write;

      alu_op           <= held ? src_alu_op : '0;
      alu_src_b        <= held ? src_ctrl.alu_src_b : SRC_B_REG;
      mem_to_reg       <= held & src_ctrl.mem_to_reg;
      immediate        <= held & src_ctrl.immediate;
      wrflag           <= held & src_ctrl.wrflag;
      write_reg        <= held ? src_write_reg : '0;
      srca             <= held ? src_srca : '0;
      mem_to_read_from <= held ? src_addr : '0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. The driver walks each
// instruction through the phases it must take (known in advance from the
// opcode and the mem_ready delay it chooses) and publishes the output word
// expected after every clock edge; a compare process checks it. A monitor
// measures handshake-to-PC_EN latency for the literal latency checks.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] opcode = '0;
  logic [2:0] wr_reg = '0;
  logic       mem_ready = 1'b0;
  logic [3:0] alu_op;
  logic [1:0] alu_src_b;
  logic       reg_write, mem_read, mem_write, mem_to_reg, immediate, wrflag;
  logic [2:0] write_reg, srca;
  logic [8:0] mem_to_read_from;
  logic       pc_en, halted, illegal, timeout;

  multicycle_control dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .opcode          (opcode),
    .wr_reg          (wr_reg),
    .mem_ready       (mem_ready),
    .alu_op          (alu_op),
    .alu_src_b       (alu_src_b),
    .reg_write       (reg_write),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_to_reg      (mem_to_reg),
    .immediate       (immediate),
    .wrflag          (wrflag),
    .write_reg       (write_reg),
    .srca            (srca),
    .mem_to_read_from(mem_to_read_from),
    .pc_en           (pc_en),
    .halted          (halted),
    .illegal         (illegal),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       instr_ready;
    logic [3:0] alu_op;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       immediate;
    logic       wrflag;
    logic [2:0] write_reg;
    logic [2:0] srca;
    logic [8:0] addr;
    logic       pc_en;
    logic       halted;
    logic       illegal;
    logic       timeout;
  } obs_t;

  typedef enum {PH_IDLE, PH_FETCH, PH_DECODE, PH_EXEC, PH_MEM, PH_WB, PH_HALT} phase_t;

  obs_t act;
  assign act = {instr_ready, alu_op, alu_src_b, reg_write, mem_read, mem_write,
                mem_to_reg, immediate, wrflag, write_reg, srca, mem_to_read_from,
                pc_en, halted, illegal, timeout};

  int   n_vec = 0;
  int   n_bad = 0;
  obs_t want = '0;
  bit   want_on = 1'b0;
  bit   m_illegal = 1'b0;
  bit   m_timeout = 1'b0;

  // Monitor results.
  int   since_hs = 100000;
  int   rd_cnt = 0;
  int   last_lat = 0;
  int   last_rd = 0;
  int   pc_cnt = 0;
  obs_t wb_obs = '0;

  // Instruction table: the full decoded word each opcode must produce.
  function automatic obs_t spec_word(input int op, input int wr);
    obs_t w;
    w = '0;
    w.alu_op = (op <= 10) ? 4'(op) : 4'd0;
    case (op)
      0, 2: w.reg_write = 1'b1;
      3: begin
        w.mem_read = 1'b1; w.mem_to_reg = 1'b1; w.alu_src_b = 2'd2; w.reg_write = 1'b1;
        if (wr >= 1 && wr <= 3) begin
          w.wrflag    = 1'b1;
          w.write_reg = 3'(wr);
          w.addr      = (wr == 1) ? 9'd18 : (wr == 2) ? 9'd19 : 9'd96;
        end
      end
      4: begin w.mem_read = 1'b1; w.reg_write = 1'b1; w.write_reg = 3'd3; w.srca = 3'd1; end
      5: begin
        w.immediate = 1'b1; w.alu_src_b = 2'd2; w.reg_write = 1'b1;
        w.write_reg = 3'd6; w.srca = 3'd6;
      end
      6: begin w.mem_write = 1'b1; w.immediate = 1'b1; w.srca = 3'd7; end
      7: begin w.immediate = 1'b1; w.reg_write = 1'b1; w.write_reg = 3'd6; end
      8: begin
        w.mem_read = 1'b1; w.mem_to_reg = 1'b1; w.reg_write = 1'b1;
        w.write_reg = 3'd7; w.srca = 3'd7;
      end
      9:  begin w.reg_write = 1'b1; w.write_reg = 3'd7; w.srca = 3'd6; end
      10: begin w.immediate = 1'b1; w.reg_write = 1'b1; w.write_reg = 3'd6; w.srca = 3'd6; end
      default: ;
    endcase
    return w;
  endfunction

  // Outputs visible while the sequencer is in a given phase.
  function automatic obs_t snap(input phase_t ph, input obs_t w);
    obs_t e;
    e = '0;
    if (ph == PH_EXEC || ph == PH_MEM || ph == PH_WB) begin
      e.alu_op = w.alu_op;     e.alu_src_b = w.alu_src_b; e.mem_to_reg = w.mem_to_reg;
      e.immediate = w.immediate; e.wrflag = w.wrflag;     e.write_reg = w.write_reg;
      e.srca = w.srca;         e.addr = w.addr;
    end
    if (ph == PH_EXEC || ph == PH_MEM) begin
      e.mem_read  = w.mem_read;
      e.mem_write = w.mem_write;
    end
    if (ph == PH_WB) begin
      e.reg_write = w.reg_write;
      e.pc_en     = 1'b1;
    end
    e.instr_ready = (ph == PH_FETCH);
    e.halted      = (ph == PH_HALT);
    e.illegal     = m_illegal;
    e.timeout     = m_timeout;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    n_vec++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp_v, $time);
    end
  endtask

  // Per-cycle comparison against the published expectation.
  always @(posedge clk) begin
    #1;
    if (want_on) begin
      n_vec++;
      if (act !== want) begin
        n_bad++;
        $display("FAIL cycle_compare: got %h expected %h at %0t", act, want, $time);
      end
    end
  end

  // Latency / memory-read-cycle monitor.
  always @(posedge clk) begin
    if (instr_valid && instr_ready) begin
      since_hs = 0;
      rd_cnt   = 0;
    end
    #1;
    if (since_hs < 100000) since_hs++;
    if (mem_read) rd_cnt++;
    if (pc_en) begin
      last_lat = since_hs;
      last_rd  = rd_cnt;
      pc_cnt++;
      wb_obs   = act;
    end
  end

  // Publish what the outputs must be after the coming edge, then advance.
  task automatic cycle(input obs_t e);
    want    = e;
    want_on = 1'b1;
    @(negedge clk);
  endtask

  task automatic noise();
    start       = 1'($urandom);
    instr_valid = 1'($urandom);
    opcode      = 4'($urandom);
    wr_reg      = 3'($urandom);
    mem_ready   = 1'($urandom);
  endtask

  // Reset, then IDLE -> FETCH. Leaves the sequencer in FETCH.
  task automatic do_reset();
    want_on   = 1'b0;
    rst_n     = 1'b0;
    m_illegal = 1'b0;
    m_timeout = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    noise(); start = 1'b0;
    cycle(snap(PH_IDLE, '0));
    noise(); start = 1'b0;
    cycle(snap(PH_IDLE, '0));
    noise(); start = 1'b1;
    cycle(snap(PH_FETCH, '0));
  endtask

  // One instruction from FETCH. ready_at: MEM_WAIT cycle (1..15) on which
  // mem_ready is raised; 0 means never.
  task automatic run_instr(input int op, input int wr, input int gap, input int ready_at);
    obs_t w;
    bit   mem_op;
    w      = spec_word(op, wr);
    mem_op = w.mem_read | w.mem_write;
    for (int g = 0; g < gap; g++) begin
      noise(); instr_valid = 1'b0;
      cycle(snap(PH_FETCH, w));
    end
    noise(); instr_valid = 1'b1; opcode = 4'(op); wr_reg = 3'(wr);
    cycle(snap(PH_DECODE, w));
    noise();
    if (op == 1 || (op >= 11 && op <= 14)) begin
      if (op != 1) m_illegal = 1'b1;
      cycle(snap(PH_HALT, w));
      return;
    end
    cycle(snap(PH_EXEC, w));
    noise();
    if (!mem_op) begin
      cycle(snap(PH_WB, w));
    end else begin
      cycle(snap(PH_MEM, w));
      for (int k = 1; k <= 15; k++) begin
        noise(); mem_ready = (k == ready_at);
        if (k == ready_at) begin
          cycle(snap(PH_WB, w));
          break;
        end else if (k == 15) begin
          m_timeout = 1'b1;
          cycle(snap(PH_HALT, w));
          return;
        end else begin
          cycle(snap(PH_MEM, w));
        end
      end
    end
    noise();
    cycle(snap(PH_FETCH, w));
  endtask

  task automatic stay_halted(input int n);
    for (int i = 0; i < n; i++) begin
      noise(); start = 1'b1;
      cycle(snap(PH_HALT, '0));
    end
  endtask

  initial begin
    int   legal_ops [11] = '{0, 2, 3, 4, 5, 6, 7, 8, 9, 10, 15};
    obs_t w8;
    int   pc_before;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs", act, 32'h0);
    do_reset();

    // ADD: PC_EN in the third cycle after the handshake.
    run_instr(0, 4, 0, 0);
    check("add_latency", last_lat, 3);
    check("add_alu_op", wb_obs.alu_op, 0);
    check("add_reg_write_in_wb", wb_obs.reg_write, 1);

    // WRREG, WR_REG=2, mem_ready on the second wait cycle.
    run_instr(3, 2, 1, 2);
    check("wrreg2_latency", last_lat, 5);
    check("wrreg2_mem_read_cycles", last_rd, 3);
    check("wrreg2_addr", wb_obs.addr, 19);
    check("wrreg2_wrflag", wb_obs.wrflag, 1);
    check("wrreg2_write_reg", wb_obs.write_reg, 2);

    // WRREG with an undefined selector.
    run_instr(3, 5, 0, 1);
    check("wrreg5_addr", wb_obs.addr, 0);
    check("wrreg5_wrflag", wb_obs.wrflag, 0);
    check("wrreg5_write_reg", wb_obs.write_reg, 0);
    check("wrreg5_latency", last_lat, 4);

    // mem_ready exactly on the last allowed wait cycle is a success.
    run_instr(4, 0, 0, 15);
    check("last_cycle_latency", last_lat, 18);
    check("last_cycle_mem_read_cycles", last_rd, 16);
    check("last_cycle_no_timeout", timeout, 0);

    // Randomised instruction stream.
    for (int i = 0; i < 40; i++) begin
      int op, ra;
      op = legal_ops[$urandom_range(0, 10)];
      ra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : $urandom_range(1, 3);
      run_instr(op, $urandom_range(0, 7), $urandom_range(0, 2), ra);
    end

    // Reset during MEM_WAIT of RXOR.
    w8 = spec_word(8, 1);
    noise(); instr_valid = 1'b1; opcode = 4'd8; wr_reg = 3'd1;
    cycle(snap(PH_DECODE, w8));
    noise(); cycle(snap(PH_EXEC, w8));
    noise(); cycle(snap(PH_MEM, w8));
    noise(); mem_ready = 1'b0; cycle(snap(PH_MEM, w8));
    want_on = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("reset_mid_mem_wait", act, 32'h0);
    do_reset();
    check("fetch_after_reset", instr_ready, 1);
    run_instr(2, 0, 0, 0);

    // WRMEM with memory never ready: timeout, then terminal HALT.
    run_instr(6, 3, 0, 0);
    check("timeout_set", timeout, 1);
    check("timeout_halted", halted, 1);
    check("timeout_mem_write_dropped", mem_write, 0);
    stay_halted(6);
    check("halt_ignores_start", instr_ready, 0);
    check("timeout_not_illegal", illegal, 0);

    // Illegal opcode.
    do_reset();
    pc_before = pc_cnt;
    run_instr(12, 0, 0, 0);
    stay_halted(5);
    check("illegal_set", illegal, 1);
    check("illegal_halted", halted, 1);
    check("illegal_no_timeout", timeout, 0);
    check("illegal_no_pc_en", pc_cnt, pc_before);

    // HALT opcode: halts without a fault flag.
    do_reset();
    run_instr(9, 2, 0, 0);
    run_instr(1, 0, 1, 0);
    stay_halted(3);
    check("halt_op_halted", halted, 1);
    check("halt_op_not_illegal", illegal, 0);

    want_on = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule
